// File: rtl/rgb2hsv_param_if.sv
// rgb2hsv_param_if: pixel, sync and clock-enable bundle into and out of the RGB->HSV converter
interface rgb2hsv_param_if #(
  parameter int DW = 8,
  parameter int HUE_RANGE = 256
);
  localparam int HW = $clog2(HUE_RANGE);
  logic ce;
  logic [DW-1:0] R, G, B;
  logic in_hsync, in_vsync, in_de;
  logic [HW-1:0] H;
  logic [DW-1:0] S, V;
  logic out_hsync, out_vsync, out_de;
  modport master (
    output ce, R, G, B, in_hsync, in_vsync, in_de,
    input H, S, V, out_hsync, out_vsync, out_de
  );
  modport slave (
    input ce, R, G, B, in_hsync, in_vsync, in_de,
    output H, S, V, out_hsync, out_vsync, out_de
  );
endinterface

// File: rtl/rgb2hsv_param.sv
// rgb2hsv_param: pipelined RGB->HSV with restoring dividers and latency-matched sync/de
module rgb2hsv_param #(
  parameter int DW = 8,
  parameter int HUE_RANGE = 256
) (
  input logic clk,
  input logic rst,
  rgb2hsv_param_if.slave bus
);
  localparam int HW = $clog2(HUE_RANGE);
  localparam int Q = DW > HW ? DW : HW;
  localparam int RW = DW + 4;
  localparam int NW = Q + RW;
  typedef struct packed {
    logic [2:0] sy;
    logic zs, zh;
    logic [DW-1:0] v;
    logic [RW-1:0] ds, dh, rs, rh;
    logic [Q-1:0] ns, nh;
  } lane_t;
  logic [DW-1:0] r0, g0, b0;
  logic [2:0] y0;
  logic [DW-1:0] v1, d1;
  logic [RW-1:0] d61, h61;
  logic zs1, zh1;
  logic [2:0] y1;
  logic mr, mg;
  logic [DW-1:0] mx, mn;
  logic [RW-1:0] dx, er, eg, eb, d6, h6a, h6;
  logic [NW-1:0] ns_n, nh_n;
  lane_t p0;
  lane_t p [1:Q];
  // Each divider step shifts one numerator bit into the remainder and emits one quotient bit;
  // the numerator's low bits and the growing quotient share the same shift field.
  function automatic lane_t step(lane_t a);
    lane_t b;
    logic [RW-1:0] xs, xh;
    b = a;
    xs = {a.rs[RW-2:0], a.ns[Q-1]};
    xh = {a.rh[RW-2:0], a.nh[Q-1]};
    b.rs = xs >= a.ds ? xs - a.ds : xs;
    b.ns = {a.ns[Q-2:0], xs >= a.ds};
    b.rh = xh >= a.dh ? xh - a.dh : xh;
    b.nh = {a.nh[Q-2:0], xh >= a.dh};
    return b;
  endfunction
  // Max/min, sector (tie priority R > G > B) and hue numerator h6 wrapped into 0..6*delta-1
  always_comb begin
    mr = r0 >= g0 && r0 >= b0;
    mg = g0 >= b0;
    mx = mr ? r0 : mg ? g0 : b0;
    mn = (r0 <= g0 && r0 <= b0) ? r0 : g0 <= b0 ? g0 : b0;
    dx = RW'(mx - mn);
    er = RW'(r0);
    eg = RW'(g0);
    eb = RW'(b0);
    d6 = (dx << 2) + (dx << 1);
    h6a = mr ? eg - eb : mg ? (dx << 1) + eb - er : (dx << 2) + er - eg;
    h6 = h6a[RW-1] ? h6a + d6 : h6a;
  end
  // Divider entry: the quotient is known to fit Q bits, so the top of each numerator is already below the divisor
  always_comb begin
    ns_n = NW'(d1) * NW'((1 << DW) - 1);
    nh_n = NW'(h61) * NW'(HUE_RANGE);
    p0 = '{sy: y1, zs: zs1, zh: zh1, v: v1, ds: RW'(v1), dh: d61,
           rs: ns_n[Q +: RW], ns: ns_n[Q-1:0], rh: nh_n[Q +: RW], nh: nh_n[Q-1:0]};
  end
  // Input register and classification stage
  always_ff @(posedge clk)
    if (rst) begin
      {r0, g0, b0, y0} <= '0;
      {v1, d1, d61, h61, zs1, zh1, y1} <= '0;
    end else if (bus.ce) begin
      r0 <= bus.R;
      g0 <= bus.G;
      b0 <= bus.B;
      y0 <= {bus.in_hsync, bus.in_vsync, bus.in_de};
      v1 <= mx;
      d1 <= mx - mn;
      d61 <= d6;
      h61 <= h6;
      zs1 <= mx == '0;
      zh1 <= mx == mn;
      y1 <= y0;
    end
  // Q divider stages, S and H lanes side by side
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 1; k <= Q; k++) p[k] <= '0;
    end else if (bus.ce) begin
      p[1] <= step(p0);
      for (int k = 2; k <= Q; k++) p[k] <= step(p[k-1]);
    end
  // Output register applies the divide-by-zero overrides
  always_ff @(posedge clk)
    if (rst) begin
      bus.H <= '0;
      bus.S <= '0;
      bus.V <= '0;
      {bus.out_hsync, bus.out_vsync, bus.out_de} <= '0;
    end else if (bus.ce) begin
      bus.H <= p[Q].zh ? '0 : p[Q].nh[HW-1:0];
      bus.S <= p[Q].zs ? '0 : p[Q].ns[DW-1:0];
      bus.V <= p[Q].v;
      {bus.out_hsync, bus.out_vsync, bus.out_de} <= p[Q].sy;
    end
endmodule

// File: tb/tb_rgb2hsv_param.sv
// tb_rgb2hsv_param: scoreboard bench for three converter configurations (8/256, 8/180, 10/256)
module tb_rgb2hsv_param;
  typedef struct packed {
    logic [11:0] h, s, v;
    logic [1:0] sy;
    logic [31:0] tag;
  } ent_t;
  typedef struct packed {
    logic [11:0] h, s, v;
    logic [1:0] sy;
    logic de;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic [9:0] ri = '0, gi = '0, bi = '0;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0;
  int lat [3] = '{11, 11, 13};
  int ex [9];
  int cnt = 0, nvec = 0, nerr = 0;
  ent_t sq [3][$];
  obs_t o [3];
  obs_t last [3];
  logic lv [3];
  // r, g, b, then H/S/V for 8-bit/256, 8-bit/180 and 10-bit/256 (8-bit units see the low 8 input bits)
  int tv [9][12] = '{
    '{255,   0,   0,   0, 255, 255,   0, 255, 255,   0, 1023,  255},
    '{  0, 255,   0,  85, 255, 255,  60, 255, 255,  85, 1023,  255},
    '{  0,   0, 255, 170, 255, 255, 120, 255, 255, 170, 1023,  255},
    '{128, 128, 128,   0,   0, 128,   0,   0, 128,   0,    0,  128},
    '{  0,   0,   0,   0,   0,   0,   0,   0,   0,   0,    0,    0},
    '{255,   0, 255, 213, 255, 255, 150, 255, 255, 213, 1023,  255},
    '{200, 100,  50,  14, 191, 200,  10, 191, 200,  14,  767,  200},
    '{255, 255,   0,  42, 255, 255,  30, 255, 255,  42, 1023,  255},
    '{1023,  0,   0,   0, 255, 255,   0, 255, 255,   0, 1023, 1023}
  };
  rgb2hsv_param_if #(.DW(8), .HUE_RANGE(256)) b0 ();
  rgb2hsv_param_if #(.DW(8), .HUE_RANGE(180)) b1 ();
  rgb2hsv_param_if #(.DW(10), .HUE_RANGE(256)) b2 ();
  rgb2hsv_param #(.DW(8), .HUE_RANGE(256)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  rgb2hsv_param #(.DW(8), .HUE_RANGE(180)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  rgb2hsv_param #(.DW(10), .HUE_RANGE(256)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  assign {b0.ce, b1.ce, b2.ce} = {3{ce}};
  assign {b0.in_hsync, b1.in_hsync, b2.in_hsync} = {3{hs}};
  assign {b0.in_vsync, b1.in_vsync, b2.in_vsync} = {3{vs}};
  assign {b0.in_de, b1.in_de, b2.in_de} = {3{de}};
  assign b0.R = ri[7:0];
  assign b0.G = gi[7:0];
  assign b0.B = bi[7:0];
  assign b1.R = ri[7:0];
  assign b1.G = gi[7:0];
  assign b1.B = bi[7:0];
  assign b2.R = ri;
  assign b2.G = gi;
  assign b2.B = bi;
  assign o[0] = '{h: 12'(b0.H), s: 12'(b0.S), v: 12'(b0.V), sy: {b0.out_hsync, b0.out_vsync}, de: b0.out_de};
  assign o[1] = '{h: 12'(b1.H), s: 12'(b1.S), v: 12'(b1.V), sy: {b1.out_hsync, b1.out_vsync}, de: b1.out_de};
  assign o[2] = '{h: 12'(b2.H), s: 12'(b2.S), v: 12'(b2.V), sy: {b2.out_hsync, b2.out_vsync}, de: b2.out_de};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h at t=%0t", nm, i, act, exp, $time);
    end
  endtask
  function automatic void model(input int dw, input int hr, input int r, input int g, input int b,
                                output int h, output int s, output int v);
    int mx, mn, d, h6;
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    d = mx - mn;
    if (r == mx) h6 = g - b;
    else if (g == mx) h6 = 2 * d + b - r;
    else h6 = 4 * d + r - g;
    if (h6 < 0) h6 += 6 * d;
    v = mx;
    s = mx == 0 ? 0 : d * ((1 << dw) - 1) / mx;
    h = d == 0 ? 0 : h6 * hr / (6 * d);
  endfunction
  task automatic cyc(input logic c, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                     input logic hsy, input logic vsy, input logic d);
    @(negedge clk);
    ce = c;
    ri = r;
    gi = g;
    bi = b;
    hs = hsy;
    vs = vsy;
    de = d;
    if (c && d)
      for (int i = 0; i < 3; i++)
        sq[i].push_back('{h: 12'(ex[3*i]), s: 12'(ex[3*i+1]), v: 12'(ex[3*i+2]), sy: {hsy, vsy}, tag: 32'(cnt)});
  endtask
  task automatic rnd(input logic c, input logic d);
    int r, g, b, m;
    r = $urandom_range(0, 1023);
    g = $urandom_range(0, 1023);
    b = $urandom_range(0, 1023);
    for (int i = 0; i < 3; i++) begin
      m = i == 2 ? 1023 : 255;
      model(i == 2 ? 10 : 8, i == 1 ? 180 : 256, r & m, g & m, b & m, ex[3*i], ex[3*i+1], ex[3*i+2]);
    end
    cyc(c, 10'(r), 10'(g), 10'(b), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) sq[i].delete();
    @(negedge clk);
    rst = 1'b0;
    de = 1'b0;
  endtask
  // Monitor: pops the scoreboard on every ce edge where a pixel is due, checks hold on ce=0 and clear on rst
  always @(posedge clk) begin : mon
    logic ce_e, rst_e, due;
    ent_t e;
    ce_e = ce;
    rst_e = rst;
    #1;
    if (!rst_e && ce_e) cnt++;
    for (int i = 0; i < 3; i++) begin
      if (rst_e) begin
        chk("reset_clear", i, 64'(o[i]), 64'(0));
        last[i] = '0;
        lv[i] = 1'b1;
      end else if (ce_e) begin
        due = sq[i].size() > 0 && cnt - int'(sq[i][0].tag) >= lat[i];
        chk("de_timing", i, 64'(o[i].de), 64'(due));
        if (due) begin
          e = sq[i].pop_front();
          chk("H", i, 64'(o[i].h), 64'(e.h));
          chk("S", i, 64'(o[i].s), 64'(e.s));
          chk("V", i, 64'(o[i].v), 64'(e.v));
          chk("sync", i, 64'(o[i].sy), 64'(e.sy));
          last[i] = '{h: e.h, s: e.s, v: e.v, sy: e.sy, de: 1'b1};
          lv[i] = 1'b1;
        end else lv[i] = 1'b0;
      end else if (lv[i]) chk("hold", i, 64'(o[i]), 64'(last[i]));
    end
  end
  // Stimulus: reset, directed table, random ce/de stream, mid-stream reset, drain
  initial begin
    do_reset();
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 9; j++) ex[j] = tv[k][3+j];
      cyc(1'b1, 10'(tv[k][0]), 10'(tv[k][1]), 10'(tv[k][2]), 1'(k), 1'(k >> 1), 1'b1);
    end
    for (int k = 0; k < 300; k++) rnd($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
    for (int k = 0; k < 6; k++) rnd(1'b1, 1'b1);
    do_reset();
    for (int k = 0; k < 30; k++) rnd(1'b1, 1'b1);
    for (int k = 0; k < 40; k++) rnd($urandom_range(0, 1) == 1, 1'b1);
    for (int k = 0; k < 25; k++) rnd(1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("drained", i, 64'(sq[i].size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
